// File: rtl/riscv_dcache_mem_responder_if.sv
// Line-refill/write-back bus between the data cache (master) and its memory responder (slave).
interface riscv_dcache_mem_responder_if #(
    parameter int AWIDTH = 23,
    parameter int DWIDTH = 128
);
    logic              i_riscv_dmem_rden;
    logic              i_riscv_dmem_wren;
    logic [AWIDTH-1:0] i_riscv_dmem_addr;
    logic [DWIDTH-1:0] i_riscv_dmem_data_in;
    logic [DWIDTH-1:0] o_riscv_dmem_data_out;
    logic              o_riscv_dmem_ready;
    logic              o_riscv_dmem_busy;

    modport master (
        output i_riscv_dmem_rden, i_riscv_dmem_wren, i_riscv_dmem_addr, i_riscv_dmem_data_in,
        input  o_riscv_dmem_data_out, o_riscv_dmem_ready, o_riscv_dmem_busy
    );

    modport slave (
        input  i_riscv_dmem_rden, i_riscv_dmem_wren, i_riscv_dmem_addr, i_riscv_dmem_data_in,
        output o_riscv_dmem_data_out, o_riscv_dmem_ready, o_riscv_dmem_busy
    );
endinterface

// File: rtl/riscv_dcache_mem_responder.sv
// Fixed-latency line memory behind the data cache; one 128-bit read or write per transaction.
// Optional RISCV_DMEM_STATS_EN adds saturating read/write commit counters.
//
// state  | meaning
// IDLE   | waiting for rden/wren; request captured on the accepting edge
// ACCESS | counting down LATENCY-1..0; array access commits on the zero edge
// RESP   | ready pulses for this one cycle, then back to IDLE regardless of inputs
module riscv_dcache_mem_responder #(
    parameter int AWIDTH    = 23,
    parameter int DWIDTH    = 128,
    parameter int MEM_DEPTH = 2**AWIDTH,
    parameter int LATENCY   = 4
) (
    input  logic                         i_riscv_dmem_clk,
    input  logic                         i_riscv_dmem_rst,
    riscv_dcache_mem_responder_if.slave  dmem_if
`ifdef RISCV_DMEM_STATS_EN
    ,
    output logic [31:0]                  o_riscv_dmem_rd_count,
    output logic [31:0]                  o_riscv_dmem_wr_count
`endif
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(MEM_DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_commit;
    logic [7:0]        r_cnt;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_op_wr;
    logic [DWIDTH-1:0] r_data_out;
    logic              r_ready;
    logic              r_busy;
    logic [IDX_W-1:0]  w_idx;
    logic [DWIDTH-1:0] r_mem [MEM_DEPTH];

    // Power-of-two depth: the modulo reduces to dropping the upper address bits.
    assign w_idx = IDX_W'({1'b0, r_addr} % DEPTH_L);

    always_ff @(posedge i_riscv_dmem_clk) begin
        if (i_riscv_dmem_rst) r_state <= IDLE;
        else                  r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem_if.i_riscv_dmem_rden || dmem_if.i_riscv_dmem_wren) begin
                    w_accept     = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == 8'd0) begin
                    w_commit     = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_dmem_clk) begin
        if (i_riscv_dmem_rst) begin
            r_cnt      <= 8'd0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= (w_state_next == RESP);
            r_busy  <= (w_state_next != IDLE);
            if (w_accept)                             r_cnt <= CNT_LOAD;
            else if (r_state == ACCESS && r_cnt != 0) r_cnt <= r_cnt - 8'd1;
            if (w_commit && !r_op_wr)                 r_data_out <= r_mem[w_idx];
        end
    end

    // Write wins a simultaneous request; the cache re-presents the read later.
    always_ff @(posedge i_riscv_dmem_clk) begin
        if (w_accept) begin
            r_addr  <= dmem_if.i_riscv_dmem_addr;
            r_wdata <= dmem_if.i_riscv_dmem_data_in;
            r_op_wr <= dmem_if.i_riscv_dmem_wren;
        end
    end

    always_ff @(posedge i_riscv_dmem_clk) begin
        if (w_commit && r_op_wr && !i_riscv_dmem_rst) r_mem[w_idx] <= r_wdata;
    end

    assign dmem_if.o_riscv_dmem_data_out = r_data_out;
    assign dmem_if.o_riscv_dmem_ready    = r_ready;
    assign dmem_if.o_riscv_dmem_busy     = r_busy;

`ifdef RISCV_DMEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge i_riscv_dmem_clk) begin
        if (i_riscv_dmem_rst) begin
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else if (w_commit) begin
            if (!r_op_wr && r_rd_count != 32'hFFFF_FFFF) r_rd_count <= r_rd_count + 32'd1;
            if (r_op_wr && r_wr_count != 32'hFFFF_FFFF)  r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign o_riscv_dmem_rd_count = r_rd_count;
    assign o_riscv_dmem_wr_count = r_wr_count;
`endif
endmodule

// File: doc/riscv_dcache_mem_responder.md
Name: riscv_dcache_mem_responder

Overview:
- Memory-side responder for the data cache's line-refill/write-back port.
- Accepts one 128-bit line read or write per transaction, holds a line-addressed backing array, and answers after a programmable fixed latency with a one-cycle ready pulse.
- Sits below the data cache and replaces the single-cycle memory model. It is the slave end of the cache's rden/wren/addr/data/ready memory protocol.

Parameters:
- AWIDTH, 23, line address width (tag+index bits).
- DWIDTH, 128, line data width.
- MEM_DEPTH, 2**AWIDTH, number of lines in the backing array.
- LATENCY, 4, cycles from request sample to ready pulse; legal range 1..255.

Ports:
- i_riscv_dmem_clk  in  1  clock.
- i_riscv_dmem_rst  in  1  synchronous active-high reset.
- i_riscv_dmem_rden  in  1  line read request, level, held by cache until ready.
- i_riscv_dmem_wren  in  1  line write request, level, held by cache until ready.
- i_riscv_dmem_addr  in  AWIDTH  line address.
- i_riscv_dmem_data_in  in  DWIDTH  write line data.
- o_riscv_dmem_data_out  out  DWIDTH  read line data, registered.
- o_riscv_dmem_ready  out  1  one-cycle completion pulse.
- o_riscv_dmem_busy  out  1  high in any state other than IDLE.

Behaviour:
- Single clock. Reset is synchronous, active-high.
- Reset values:
  - FSM = IDLE.
  - data_out = 0.
  - ready = 0.
  - busy = 0.
  - Latency counter = 0.
  - Backing array is NOT reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On a rising edge with rden|wren high, capture addr, data_in and op into internal registers.
  - Load counter = LATENCY-1, go to ACCESS.
  - Simultaneous rden and wren: the write is taken (write-back before refill); the read is not queued, and the cache re-presents it later.
- ACCESS:
  - Inputs are ignored; only the captured values are used.
  - While counter != 0, decrement the counter each edge.
  - On the edge with counter == 0:
    - Read: data_out <= array[captured addr].
    - Write: array[captured addr] <= captured data.
    - Go to RESP.
- RESP:
  - ready = 1 for exactly this cycle.
  - data_out is valid this cycle and holds its value until the next read completes.
  - Next edge goes unconditionally to IDLE. A request still asserted on the edge leaving RESP is NOT accepted, which prevents double-servicing a request the cache is dropping.
- Timing: if a request is sampled at edge E0, ready is high in the cycle following edge E(LATENCY). Minimum spacing between request accepts is LATENCY+2 cycles.
- Address wrap: index = addr mod MEM_DEPTH. MEM_DEPTH must be a power of two; the upper bits are dropped.
- Reset mid-operation:
  - Reset in ACCESS aborts the transaction. No array write occurs unless the commit edge has already passed.
  - Reset in RESP suppresses ready from the next cycle.
- Request deasserted during ACCESS: the transaction still completes and ready still pulses.
- busy = (state != IDLE), registered from state.

Optional Feature:
- Macro: RISCV_DMEM_STATS_EN.
- Defined:
  - Adds outputs o_riscv_dmem_rd_count[31:0] and o_riscv_dmem_wr_count[31:0].
  - Each counter increments on the commit edge of a read or write respectively.
  - Counters saturate at 32'hFFFF_FFFF and are cleared to 0 by reset.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Write/read with LATENCY=4:
  - Stimulus: wren, addr=0x00010, data=128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233 held until ready; then rden on the same addr.
  - Response: ready 4 cycles after each sample edge; read data_out equals the written line.
- Simultaneous request:
  - Stimulus: rden=wren=1, addr=0x00020, data=all-ones; then rden only on the same addr.
  - Response: first transaction is a write; the subsequent read returns all-ones.
- Held request after ready:
  - Stimulus: rden held 2 cycles past ready.
  - Response: exactly one ready pulse; a second accept occurs only after the IDLE return, with busy low for one cycle in between.
- Reset mid-operation:
  - Stimulus: wren addr=0x00030 data=0x55..55, reset asserted 2 cycles after accept; then a read of 0x00030.
  - Response: no ready from the aborted transaction; the read returns the prior contents (preload 0xAA..AA), not 0x55..55.
- Address wrap with MEM_DEPTH=16:
  - Stimulus: write addr=0x13, then read addr=0x03.
  - Response: read returns the line written to 0x13.
- Stats (with RISCV_DMEM_STATS_EN, LATENCY=1):
  - Stimulus: 3 writes and 2 reads.
  - Response: wr_count=3, rd_count=2; both counters are 0 after reset.
